ringosc_freq_counter: RTL
=========================

Name: ringosc_freq_counter

Overview:
Measures the frequency of the on-chip ring oscillator. It sits directly downstream of the ring oscillator: it drives the oscillator's enable, receives the free-running oscillator output, and divides that output in the oscillator domain. It then synchronizes the divided signal into the system clock domain and counts its rising edges over a programmable gate window of system clocks. The result is returned with a one-cycle done pulse, for readout by the chip-level I/O logic.

Parameters:
CNT_W, 16, width of the edge-count result
GATE_W, 16, width of the gate-window length input (system clock cycles)
DIV_LOG2, 3, oscillator prescale factor 2^DIV_LOG2; legal range 1..8
SYNC_STAGES, 2, flip-flops in the clock-domain-crossing synchronizer; minimum 2
SETTLE_CYCLES, 8, system clocks between enabling the oscillator and opening the gate

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset for the whole block, including the prescaler
start  input  1  single-cycle request to begin a measurement; sampled only in IDLE
gate_cycles  input  GATE_W  gate window length in clk cycles; latched on an accepted start
osc_in  input  1  ring oscillator output; asynchronous to clk
osc_enable  output  1  enable to the ring oscillator
busy  output  1  high from the cycle after an accepted start until done inclusive
done  output  1  one-cycle pulse; count and overflow are valid from this cycle
count  output  CNT_W  number of divided-oscillator rising edges seen in the gate window
overflow  output  1  high if the edge count saturated

Behaviour:
- Reset values: osc_enable=0, busy=0, done=0, count=0, overflow=0; FSM in IDLE; prescaler and synchronizer chain cleared to 0.
- Reset applies asynchronously at any point, including mid-measurement. The block returns to IDLE and osc_enable drops immediately; a partial result is never reported.
- Prescaler: a ripple or synchronous counter of DIV_LOG2 bits, clocked by osc_in and reset by rst_n. Its MSB (div_out) has period 2^DIV_LOG2 oscillator periods. It is the only logic in the osc_in domain.
- CDC: div_out passes through a SYNC_STAGES flop chain in the clk domain, followed by one "prev" flop.
  - edge = sync_out & ~prev.
  - The edge detector runs in every state; edges are counted only in MEASURE.
- FSM states:
  - IDLE: osc_enable=0. When start=1, latch gate_cycles into gate_q, clear the counter and overflow, and go to SETTLE.
  - SETTLE: osc_enable=1. Runs for exactly SETTLE_CYCLES cycles, then goes to MEASURE, or to DONE if gate_q==0.
  - MEASURE: osc_enable=1. Runs for exactly gate_q cycles; each cycle with edge=1 increments the counter. Then goes to DONE.
  - DONE: osc_enable=0, done=1 for one cycle, busy=1. Then goes to IDLE.
- Latency: with start accepted at cycle T, done is asserted at cycle T+1+SETTLE_CYCLES+gate_q.
- Arithmetic: the counter saturates at 2^CNT_W-1. An edge arriving while saturated sets overflow=1, which stays sticky until the next accepted start.
- count and overflow hold their values from done until the next accepted start. They clear on the cycle after that start.
- start outside IDLE (busy=1 or in the DONE cycle) is ignored, not queued.
- Accuracy: the result is within ±1 of the ideal gate_q*Tclk / (2^DIV_LOG2*Tosc). The divided frequency must be below f_clk/2; the divided signal is undersampled above that, and this is the integrator's responsibility when choosing DIV_LOG2.
- gate_cycles changes after an accepted start have no effect.

Decomposition:
- Shared package ringosc_pkg holds:
  - the FSM state enum (IDLE, SETTLE, MEASURE, DONE) as a 2-bit typedef;
  - default constants for CNT_W, GATE_W, DIV_LOG2, SETTLE_CYCLES.
- One sub-module, ringosc_prescaler (osc_in, rst_n -> div_out). It isolates the oscillator clock domain so its timing constraints can be applied separately.
- The synchronizer chain, edge detector, FSM and counter stay in the top module.

Test Plan:
- Reset: assert rst_n=0 with osc_in toggling -> all outputs 0 and osc_enable=0. Then release, and hold start=0 for 100 cycles -> outputs unchanged.
- Nominal: clk 10 ns; bench drives osc_in with a 16 ns period only while osc_enable=1; DIV_LOG2=3; gate_cycles=1280; pulse start -> done exactly 1+8+1280 cycles later, count in 99..101, overflow=0, busy high throughout.
- Zero gate: gate_cycles=0, start -> done 9 cycles after start, count=0, and osc_enable was high for exactly 8 cycles.
- Saturation: CNT_W=8, osc period 16 ns, gate_cycles=5000 -> count=255, overflow=1. A following run with gate_cycles=100 -> overflow=0, count≈8.
- Ignored start and held value: pulse start again mid-MEASURE and again on the done cycle -> no restart, and the done timing matches the nominal case. count stays constant for 50 idle cycles after done.
- Reset mid-measurement: drop rst_n during MEASURE -> osc_enable=0 immediately and no done pulse. After release, a fresh start gives a correct result.

Source files
------------

// File: rtl/ringosc_pkg.sv
// Shared definitions for the ring-oscillator frequency counter:
// FSM state encoding and default parameter values.
package ringosc_pkg;

  localparam int CNT_W_DEF         = 16;
  localparam int GATE_W_DEF        = 16;
  localparam int DIV_LOG2_DEF      = 3;
  localparam int SYNC_STAGES_DEF   = 2;
  localparam int SETTLE_CYCLES_DEF = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/ringosc_prescaler.sv
// Oscillator-domain prescaler: a free-running DIV_LOG2-bit counter clocked
// by the ring oscillator. Its MSB is the divided clock handed to the system
// clock domain. This is the only logic clocked by osc_in.
module ringosc_prescaler
  import ringosc_pkg::*;
#(
  parameter int DIV_LOG2 = DIV_LOG2_DEF
) (
  input  logic osc_in,
  input  logic rst_n,
  output logic div_out
);

  logic [DIV_LOG2-1:0] div_cnt_r;

  // Count oscillator rising edges; cleared only by the block reset.
  always_ff @(posedge osc_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_r <= {DIV_LOG2{1'b0}};
    end else begin
      div_cnt_r <= div_cnt_r + DIV_LOG2'(1);
    end
  end

  assign div_out = div_cnt_r[DIV_LOG2-1];

endmodule

// File: rtl/ringosc_freq_counter.sv
// Ring-oscillator frequency counter. Enables the oscillator, lets it settle,
// then counts rising edges of the synchronized divided oscillator over a
// programmable window of system clocks and reports the result with a
// one-cycle done pulse.
module ringosc_freq_counter
  import ringosc_pkg::*;
#(
  parameter int CNT_W         = CNT_W_DEF,
  parameter int GATE_W        = GATE_W_DEF,
  parameter int DIV_LOG2      = DIV_LOG2_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic              osc_in,
  output logic              osc_enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  output logic              overflow
);

  // The window timer must hold both the settle length and any gate length.
  localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMR_W    = (GATE_W > SETTLE_W) ? GATE_W : SETTLE_W;
  localparam logic [TMR_W-1:0]  TMR_ZERO    = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0]  SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};
  localparam logic [GATE_W-1:0] GATE_ZERO   = {GATE_W{1'b0}};

  logic                   div_out_s;
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   prev_r;
  logic                   sync_out_s;
  logic                   edge_s;
  state_t                 state_r;
  logic [GATE_W-1:0]      gate_q_r;
  logic [TMR_W-1:0]       timer_r;

  ringosc_prescaler #(
    .DIV_LOG2 (DIV_LOG2)
  ) u_prescaler (
    .osc_in  (osc_in),
    .rst_n   (rst_n),
    .div_out (div_out_s)
  );

  // Bring the divided clock into the clk domain and keep a delayed copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      prev_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], div_out_s};
      prev_r <= sync_out_s;
    end
  end

  assign sync_out_s = sync_r[SYNC_STAGES-1];
  assign edge_s     = sync_out_s & ~prev_r;

  // Measurement sequencer with registered outputs and saturating edge counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      gate_q_r   <= GATE_ZERO;
      timer_r    <= TMR_ZERO;
      osc_enable <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      count      <= {CNT_W{1'b0}};
      overflow   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            gate_q_r   <= gate_cycles;
            count      <= {CNT_W{1'b0}};
            overflow   <= 1'b0;
            timer_r    <= SETTLE_LOAD;
            osc_enable <= 1'b1;
            busy       <= 1'b1;
            state_r    <= SETTLE;
          end else begin
            osc_enable <= 1'b0;
            busy       <= 1'b0;
          end
        end
        SETTLE: begin
          if (timer_r == TMR_ZERO) begin
            if (gate_q_r == GATE_ZERO) begin
              osc_enable <= 1'b0;
              done       <= 1'b1;
              state_r    <= DONE;
            end else begin
              timer_r <= TMR_W'(gate_q_r) - TMR_W'(1);
              state_r <= MEASURE;
            end
          end else begin
            timer_r <= timer_r - TMR_W'(1);
          end
        end
        MEASURE: begin
          // An edge seen while already saturated marks the result as clipped.
          if (edge_s) begin
            if (count == CNT_MAX) begin
              overflow <= 1'b1;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
          if (timer_r == TMR_ZERO) begin
            osc_enable <= 1'b0;
            done       <= 1'b1;
            state_r    <= DONE;
          end else begin
            timer_r <= timer_r - TMR_W'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          osc_enable <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule
